// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: front-end control-flow unit. It owns the fetch PC,
// applies BEQ-taken / JLR redirects raised by the EX hazard unit, squashes
// the younger pipeline registers, and holds a redirect across a front-end
// stall. It also keeps a saturating count of redirects that were applied.
module pc_redirect_ctrl #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [1:0]        redir_sel,
    input  logic [ADDR_W-1:0] jlr_target,
    input  logic [ADDR_W-1:0] beq_target,
    output logic [ADDR_W-1:0] pc,
    output logic              flush_if_id,
    output logic              flush_id_rr,
    output logic              flush_rr_ex,
    output logic              redir_busy,
    output logic [CNT_W-1:0]  redir_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [1:0] SEL_JLR = 2'b01;
    localparam logic [1:0] SEL_BEQ = 2'b10;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pend_target, pend_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] target;
    logic              accept;
    logic              count_en;

    // Register update for PC, state, held target and the redirect counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pend_target <= '0;
            redir_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_target <= pend_next;
            if (count_en && (redir_count != {CNT_W{1'b1}})) begin
                redir_count <= redir_count + CNT_W'(1);
            end
        end
    end

    // Next-state, next-PC and flush decode; flushes win over stall.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        pend_next   = pend_target;
        count_en    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_rr = 1'b0;
        flush_rr_ex = 1'b0;
        redir_busy  = 1'b0;

        // Requests are only considered in IDLE; 00/11 encodings are no-ops.
        accept = (state == IDLE) && redir_valid &&
                 ((redir_sel == SEL_JLR) || (redir_sel == SEL_BEQ));
        target = (redir_sel == SEL_JLR) ? jlr_target : beq_target;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    flush_if_id = 1'b1;
                    flush_id_rr = 1'b1;
                    flush_rr_ex = 1'b1;
                    if (stall) begin
                        // Frozen front end: park the target until the stall drops.
                        pend_next  = target;
                        state_next = PENDING;
                    end else begin
                        pc_next  = target;
                        count_en = 1'b1;
                    end
                end else if (!stall) begin
                    pc_next = pc + ADDR_W'(1);
                end
            end
            PENDING: begin
                // Wrong-path fetch keeps being squashed until the redirect lands.
                redir_busy  = 1'b1;
                flush_if_id = 1'b1;
                if (!stall) begin
                    pc_next    = pend_target;
                    count_en   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // No bubbles are injected while the unit is held in reset.
        if (!rst_n) begin
            flush_if_id = 1'b0;
            flush_id_rr = 1'b0;
            flush_rr_ex = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: the driver pushes hand-computed
// expected outputs for each cycle, the monitor pops and compares them at
// the falling edge.
module tb_pc_redirect_ctrl;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0010;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [2:0]        fl;     // {if_id, id_rr, rr_ex}
        logic              busy;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              redir_valid = 1'b0;
    logic [1:0]        redir_sel = 2'b00;
    logic [ADDR_W-1:0] jlr_target = '0;
    logic [ADDR_W-1:0] beq_target = '0;
    logic [ADDR_W-1:0] pc;
    logic              flush_if_id, flush_id_rr, flush_rr_ex;
    logic              redir_busy;
    logic [CNT_W-1:0]  redir_count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    pc_redirect_ctrl #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redir_valid(redir_valid),
        .redir_sel  (redir_sel),
        .jlr_target (jlr_target),
        .beq_target (beq_target),
        .pc         (pc),
        .flush_if_id(flush_if_id),
        .flush_id_rr(flush_id_rr),
        .flush_rr_ex(flush_rr_ex),
        .redir_busy (redir_busy),
        .redir_count(redir_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc_no, act, req);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", 32'(pc), 32'(e.pc));
                check("flushes", 32'({flush_if_id, flush_id_rr, flush_rr_ex}), 32'(e.fl));
                check("redir_busy", 32'(redir_busy), 32'(e.busy));
                check("redir_count", 32'(redir_count), 32'(e.cnt));
                cyc_no++;
            end
        end
    end

    task automatic push(input logic [ADDR_W-1:0] p, input logic [2:0] f,
                        input logic b, input logic [CNT_W-1:0] c);
        exp_t e;
        e.pc = p; e.fl = f; e.busy = b; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs (just after a rising edge), queue the
    // expected outputs for that cycle, then advance past the next edge.
    task automatic cyc(input logic s, input logic v, input logic [1:0] sel,
                       input logic [ADDR_W-1:0] jt, input logic [ADDR_W-1:0] bt,
                       input logic [ADDR_W-1:0] p, input logic [2:0] f,
                       input logic b, input logic [CNT_W-1:0] c);
        stall = s; redir_valid = v; redir_sel = sel;
        jlr_target = jt; beq_target = bt;
        push(p, f, b, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state while rst_n is low, even with a valid request on the inputs.
        cyc(0, 1, 2'b10, 16'h0000, 16'h0999, 16'h0010, 3'b000, 0, 0);
        rst_n = 1'b1;

        // 1: free-running fetch from RESET_PC.
        cyc(0, 0, 2'b00, 0, 0, 16'h0010, 3'b000, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 16'h0011, 3'b000, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 16'h0012, 3'b000, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 16'h0013, 3'b000, 0, 0);
        for (int i = 16'h14; i < 16'h20; i++)
            cyc(0, 0, 2'b00, 0, 0, ADDR_W'(i), 3'b000, 0, 0);

        // 2: BEQ taken, no stall.
        cyc(0, 1, 2'b10, 16'h0BBB, 16'h0100, 16'h0020, 3'b111, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 16'h0100, 3'b000, 0, 1);
        cyc(0, 0, 2'b00, 0, 0, 16'h0101, 3'b000, 0, 1);

        // 3: JLR under stall, held for 3 more cycles; target inputs change later.
        cyc(1, 1, 2'b01, 16'h0AAA, 16'h0CCC, 16'h0102, 3'b111, 0, 1);
        cyc(1, 0, 2'b00, 16'h0EEE, 0, 16'h0102, 3'b100, 1, 1);
        cyc(1, 1, 2'b01, 16'h0EEE, 0, 16'h0102, 3'b100, 1, 1);
        cyc(1, 0, 2'b00, 16'h0EEE, 0, 16'h0102, 3'b100, 1, 1);
        cyc(0, 0, 2'b00, 16'h0EEE, 0, 16'h0102, 3'b100, 1, 1);
        cyc(0, 0, 2'b00, 0, 0, 16'h0AAA, 3'b000, 0, 2);

        // 4: sel 11 and 00 are no-ops.
        cyc(0, 1, 2'b11, 16'h0F00, 16'h0F00, 16'h0AAB, 3'b000, 0, 2);
        cyc(0, 1, 2'b00, 16'h0F00, 16'h0F00, 16'h0AAC, 3'b000, 0, 2);
        // A second request while PENDING is ignored.
        cyc(1, 1, 2'b01, 16'h0777, 16'h0F00, 16'h0AAD, 3'b111, 0, 2);
        cyc(1, 1, 2'b10, 0, 16'h0555, 16'h0AAD, 3'b100, 1, 2);
        cyc(0, 1, 2'b10, 0, 16'h0555, 16'h0AAD, 3'b100, 1, 2);
        cyc(1, 0, 2'b00, 0, 0, 16'h0777, 3'b000, 0, 3);
        // Plain stall in IDLE holds the PC.
        cyc(1, 0, 2'b00, 0, 0, 16'h0777, 3'b000, 0, 3);
        cyc(0, 0, 2'b00, 0, 0, 16'h0777, 3'b000, 0, 3);

        // 5: enter PENDING, then reset asynchronously mid-cycle.
        cyc(1, 1, 2'b10, 0, 16'h1234, 16'h0778, 3'b111, 0, 3);
        cyc(1, 0, 2'b00, 0, 0, 16'h0778, 3'b100, 1, 3);
        stall = 1'b1; redir_valid = 1'b0; redir_sel = 2'b00;
        #2 rst_n = 1'b0;
        push(RESET_PC, 3'b000, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 2'b00, 0, 0, 16'h0010, 3'b000, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 16'h0011, 3'b000, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 16'h0012, 3'b000, 0, 0);

        // 6: 17 back-to-back redirects saturate the 4-bit counter at 15.
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, (i % 2 == 0) ? 2'b10 : 2'b01, ADDR_W'(16'h0200 + i), ADDR_W'(16'h0200 + i),
                (i == 0) ? 16'h0013 : ADDR_W'(16'h0200 + i - 1), 3'b111, 0,
                CNT_W'((i > 15) ? 15 : i));
        end
        // PC wrap at the top of the address space.
        cyc(0, 1, 2'b01, 16'hFFFF, 0, 16'h0210, 3'b111, 0, 15);
        cyc(0, 0, 2'b00, 0, 0, 16'hFFFF, 3'b000, 0, 15);
        cyc(0, 0, 2'b00, 0, 0, 16'h0000, 3'b000, 0, 15);

        // Drain: the monitor must have consumed every expectation.
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
